// File: rtl/rgb565_gray_dma_ctrl.sv
// Custom-instruction programmed bus master: reads RGB565 pixel pairs, writes packed
// grayscale bytes, one 32-bit output word per group of four pixels.
module rgb565_gray_dma_ctrl #(
   parameter logic [7:0] customInstructionID = 8'd0,
   parameter int         COUNT_WIDTH         = 16
) (
   input  logic        clock,
   input  logic        nReset,
   input  logic        start,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   input  logic [7:0]  isId,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] memAddr,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] memWriteData,
   input  logic [31:0] memReadData,
   input  logic        memAck,
   output logic        irq
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD0 = 2'd1, ST_RD1 = 2'd2, ST_WR = 2'd3} state_t;

   localparam logic [1:0] OP_STATUS = 2'd0;
   localparam logic [1:0] OP_SRC    = 2'd1;
   localparam logic [1:0] OP_DST    = 2'd2;
   localparam logic [1:0] OP_LAUNCH = 2'd3;
   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   // Weighted sum peaks at 64220, so the 16-bit accumulator never overflows.
   function automatic logic [7:0] gray8(input logic [15:0] p);
      logic [15:0] acc;
      acc = {8'd0, p[15:11], 3'b000} * 16'd54
          + {8'd0, p[10:5],  2'b00}  * 16'd183
          + {8'd0, p[4:0],   3'b000} * 16'd19;
      return acc[15:8];
   endfunction

   function automatic logic [31:0] gray_pack(input logic [31:0] w0, input logic [31:0] w1);
      return {gray8(w1[31:16]), gray8(w1[15:0]), gray8(w0[31:16]), gray8(w0[15:0])};
   endfunction

   state_t                 state_r, state_nx;
   logic [31:0]            src_r, src_nx, dst_r, dst_nx;
   logic [31:0]            word0_r, word0_nx, word1_r, word1_nx;
   logic [COUNT_WIDTH-1:0] rem_r, rem_nx;
   logic                   irq_r, irq_nx, irq_set_s;
   logic [31:0]            mem_addr_r, mem_wdata_r, req_addr_s, req_data_s;
   logic                   mem_read_r, mem_write_r, req_read_s, req_write_s;
   logic                   is_me_s, busy_s;
   logic [1:0]             op_s;
   logic                   unused_s;

   assign is_me_s  = start && (isId == customInstructionID);
   assign op_s     = valueA[1:0];
   assign busy_s   = (state_r != ST_IDLE);
   assign unused_s = ^{valueA[31:2], valueB[1:0]};

   // Instruction response: STATUS always answers, the rest report 1 when rejected while busy.
   always_comb begin
      done   = is_me_s;
      result = 32'd0;
      if (is_me_s) begin
         case (op_s)
            OP_STATUS: result = {busy_s, irq_r, {(30-COUNT_WIDTH){1'b0}}, rem_r};
            default:   result = busy_s ? 32'd1 : 32'd0;
         endcase
      end else begin
         result = 32'd0;
      end
   end

   // Sequencer next state and datapath updates.
   always_comb begin
      state_nx  = state_r;
      src_nx    = src_r;
      dst_nx    = dst_r;
      rem_nx    = rem_r;
      word0_nx  = word0_r;
      word1_nx  = word1_r;
      irq_set_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (is_me_s) begin
               case (op_s)
                  OP_SRC: src_nx = {valueB[31:2], 2'b00};
                  OP_DST: dst_nx = {valueB[31:2], 2'b00};
                  OP_LAUNCH: begin
                     rem_nx = valueB[COUNT_WIDTH-1:0];
                     if (valueB[COUNT_WIDTH-1:0] == CNT_ZERO) begin
                        irq_set_s = 1'b1;
                     end else begin
                        state_nx = ST_RD0;
                     end
                  end
                  default: state_nx = ST_IDLE;
               endcase
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_RD0, ST_RD1: begin
            if (memAck) begin
               if (state_r == ST_RD0) begin
                  word0_nx = memReadData;
                  state_nx = ST_RD1;
               end else begin
                  word1_nx = memReadData;
                  state_nx = ST_WR;
               end
               src_nx = src_r + 32'd4;
            end else begin
               state_nx = state_r;
            end
         end
         ST_WR: begin
            if (memAck) begin
               dst_nx = dst_r + 32'd4;
               rem_nx = rem_r - CNT_ONE;
               if (rem_r == CNT_ONE) begin
                  state_nx  = ST_IDLE;
                  irq_set_s = 1'b1;
               end else begin
                  state_nx = ST_RD0;
               end
            end else begin
               state_nx = ST_WR;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      // Completion outranks a same-cycle STATUS clear.
      if (irq_set_s) begin
         irq_nx = 1'b1;
      end else if (is_me_s && (op_s == OP_STATUS)) begin
         irq_nx = 1'b0;
      end else begin
         irq_nx = irq_r;
      end
   end

   // Bus request for the upcoming state, registered so it holds steady until memAck.
   always_comb begin
      req_read_s  = 1'b0;
      req_write_s = 1'b0;
      req_addr_s  = 32'd0;
      req_data_s  = 32'd0;
      case (state_nx)
         ST_RD0, ST_RD1: begin
            req_read_s = 1'b1;
            req_addr_s = src_nx;
         end
         ST_WR: begin
            req_write_s = 1'b1;
            req_addr_s  = dst_nx;
            req_data_s  = gray_pack(word0_nx, word1_nx);
         end
         default: req_read_s = 1'b0;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_r     <= ST_IDLE;
         src_r       <= 32'd0;
         dst_r       <= 32'd0;
         rem_r       <= CNT_ZERO;
         word0_r     <= 32'd0;
         word1_r     <= 32'd0;
         irq_r       <= 1'b0;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
      end else begin
         state_r     <= state_nx;
         src_r       <= src_nx;
         dst_r       <= dst_nx;
         rem_r       <= rem_nx;
         word0_r     <= word0_nx;
         word1_r     <= word1_nx;
         irq_r       <= irq_nx;
         mem_addr_r  <= req_addr_s;
         mem_wdata_r <= req_data_s;
         mem_read_r  <= req_read_s;
         mem_write_r <= req_write_s;
      end
   end

   assign memAddr      = mem_addr_r;
   assign memRead      = mem_read_r;
   assign memWrite     = mem_write_r;
   assign memWriteData = mem_wdata_r;
   assign irq          = irq_r;

endmodule

// File: tb/tb_rgb565_gray_dma_ctrl.sv
// Directed bench for rgb565_gray_dma_ctrl: CPU instruction driver plus a memory
// responder with configurable acknowledge latency.
module tb_rgb565_gray_dma_ctrl;

   logic        clock = 1'b0;
   logic        nReset, start, done, memRead, memWrite, memAck, irq;
   logic [31:0] valueA, valueB, result, memAddr, memWriteData, memReadData;
   logic [7:0]  isId;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_log[$], wr_addr_log[$], wr_data_log[$];
   int delay_sel, wait_cnt, xfer_idx, cur_delay;
   int dtab [8] = '{3, 1, 4, 2, 0, 4, 1, 3};
   logic        prev_pend, prev_rd, prev_wr;
   logic [31:0] prev_addr, prev_data;

   always #5 clock = ~clock;

   rgb565_gray_dma_ctrl dut (
      .clock(clock), .nReset(nReset), .start(start), .valueA(valueA), .valueB(valueB),
      .isId(isId), .done(done), .result(result), .memAddr(memAddr), .memRead(memRead),
      .memWrite(memWrite), .memWriteData(memWriteData), .memReadData(memReadData),
      .memAck(memAck), .irq(irq)
   );

   task automatic cpu(input logic [1:0] op, input logic [31:0] b, output logic [31:0] res, output logic dn);
      start = 1'b1; isId = 8'd0; valueA = {30'd0, op}; valueB = b;
      #1; res = result; dn = done;
      @(posedge clock); #1;
      start = 1'b0; valueA = 32'd0; valueB = 32'd0;
   endtask

   task automatic wait_irq(input int budget, output int cyc);
      cyc = 0;
      while (irq !== 1'b1 && cyc < budget) begin @(posedge clock); #1; cyc++; end
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_timeout: irq=%b after %0d cycles, required 1", irq, cyc); end
   endtask

   task automatic clear_logs();
      rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); xfer_idx = 0;
   endtask

   task automatic test_reset();
      logic [31:0] r; logic d;
      n_tests++; if (memRead !== 1'b0) begin n_fail++; $display("FAIL rst_memRead: got %b, required 0", memRead); end
      n_tests++; if (memWrite !== 1'b0) begin n_fail++; $display("FAIL rst_memWrite: got %b, required 0", memWrite); end
      n_tests++; if (memAddr !== 32'd0) begin n_fail++; $display("FAIL rst_memAddr: got %h, required 0", memAddr); end
      n_tests++; if (memWriteData !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h, required 0", memWriteData); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b, required 0", irq); end
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL rst_status: got %h, required 00000000", r); end
      n_tests++; if (d !== 1'b1) begin n_fail++; $display("FAIL rst_done: got %b, required 1", d); end
   endtask

   task automatic test_single();
      logic [31:0] r; logic d; int c;
      clear_logs(); delay_sel = 0;
      mem[32'h100] = 32'h07E0F800; mem[32'h104] = 32'hFFFF001F;
      cpu(2'd1, 32'h100, r, d);
      n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL src_result: got %h, required 0", r); end
      cpu(2'd2, 32'h203, r, d);
      cpu(2'd3, 32'd1, r, d);
      wait_irq(50, c);
      n_tests++; if (c !== 3) begin n_fail++; $display("FAIL single_latency: got %0d cycles, required 3", c); end
      n_tests++; if (wr_addr_log.size() !== 1) begin n_fail++; $display("FAIL single_wr_count: got %0d, required 1", wr_addr_log.size()); end
      else begin
         n_tests++; if (wr_addr_log[0] !== 32'h200) begin n_fail++; $display("FAIL single_wr_addr: got %h, required 00000200", wr_addr_log[0]); end
         n_tests++; if (wr_data_log[0] !== 32'hFA12B434) begin n_fail++; $display("FAIL single_wr_data: got %h, required fa12b434", wr_data_log[0]); end
      end
      n_tests++; if (rd_log.size() !== 2) begin n_fail++; $display("FAIL single_rd_count: got %0d, required 2", rd_log.size()); end
      else begin
         n_tests++; if (rd_log[0] !== 32'h100 || rd_log[1] !== 32'h104) begin n_fail++; $display("FAIL single_rd_addr: got %h %h, required 00000100 00000104", rd_log[0], rd_log[1]); end
      end
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL single_status: got %h, required 40000000", r); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_clear: got %b, required 0", irq); end
   endtask

   task automatic test_multi();
      logic [31:0] r; logic d; int c;
      logic [31:0] exp_wr [3] = '{32'hFA12B434, 32'hFAFA0000, 32'h12B43400};
      clear_logs(); delay_sel = 1;
      mem[32'h108] = 32'h00000000; mem[32'h10C] = 32'hFFFFFFFF;
      mem[32'h110] = 32'hF8000000; mem[32'h114] = 32'h001F07E0;
      cpu(2'd1, 32'h100, r, d);
      cpu(2'd2, 32'h200, r, d);
      cpu(2'd3, 32'd3, r, d);
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'h80000003) begin n_fail++; $display("FAIL multi_status3: got %h, required 80000003", r); end
      cpu(2'd2, 32'h999, r, d);
      n_tests++; if (r !== 32'd1 || d !== 1'b1) begin n_fail++; $display("FAIL busy_dst: got %h done=%b, required 00000001 done=1", r, d); end
      for (int k = 1; k <= 2; k++) begin
         c = 0;
         while (wr_addr_log.size() < k && c < 100) begin @(posedge clock); #1; c++; end
         cpu(2'd0, 32'd0, r, d);
         n_tests++; if (r !== (32'h80000000 | (32'd3 - k))) begin n_fail++; $display("FAIL multi_status_rem: got %h, required %h", r, 32'h80000000 | (32'd3 - k)); end
      end
      wait_irq(200, c);
      n_tests++; if (rd_log.size() !== 6) begin n_fail++; $display("FAIL multi_rd_count: got %0d, required 6", rd_log.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            n_tests++; if (rd_log[i] !== 32'h100 + 32'(4 * i)) begin n_fail++; $display("FAIL multi_rd_addr%0d: got %h, required %h", i, rd_log[i], 32'h100 + 32'(4 * i)); end
         end
      end
      n_tests++; if (wr_addr_log.size() !== 3) begin n_fail++; $display("FAIL multi_wr_count: got %0d, required 3", wr_addr_log.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++; if (wr_addr_log[i] !== 32'h200 + 32'(4 * i)) begin n_fail++; $display("FAIL multi_wr_addr%0d: got %h, required %h", i, wr_addr_log[i], 32'h200 + 32'(4 * i)); end
            n_tests++; if (wr_data_log[i] !== exp_wr[i]) begin n_fail++; $display("FAIL multi_wr_data%0d: got %h, required %h", i, wr_data_log[i], exp_wr[i]); end
         end
      end
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL multi_status_end: got %h, required 40000000", r); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; logic d;
      clear_logs(); delay_sel = 0;
      cpu(2'd1, 32'h800, r, d);
      cpu(2'd2, 32'h900, r, d);
      cpu(2'd3, 32'd2, r, d);
      repeat (5) begin @(posedge clock); #1; end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL b2b_early_irq: got %b, required 0", irq); end
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'h80000001) begin n_fail++; $display("FAIL b2b_status_last: got %h, required 80000001", r); end
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL b2b_set_priority: irq=%b, required 1", irq); end
      n_tests++; if (wr_addr_log.size() !== 2) begin n_fail++; $display("FAIL b2b_wr_count: got %0d, required 2", wr_addr_log.size()); end
      else begin
         n_tests++; if (wr_addr_log[0] !== 32'h900 || wr_addr_log[1] !== 32'h904) begin n_fail++; $display("FAIL b2b_wr_addr: got %h %h, required 00000900 00000904", wr_addr_log[0], wr_addr_log[1]); end
      end
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL b2b_status_end: got %h, required 40000000", r); end
   endtask

   task automatic test_launch0();
      logic [31:0] r; logic d;
      clear_logs(); delay_sel = 0;
      cpu(2'd3, 32'd0, r, d);
      n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL l0_result: got %h, required 0", r); end
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL l0_irq: got %b, required 1", irq); end
      n_tests++; if (memRead !== 1'b0 || memWrite !== 1'b0) begin n_fail++; $display("FAIL l0_no_bus: rd=%b wr=%b, required 0 0", memRead, memWrite); end
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL l0_status1: got %h, required 40000000", r); end
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL l0_status2: got %h, required 00000000", r); end
      n_tests++; if (rd_log.size() + wr_addr_log.size() !== 0) begin n_fail++; $display("FAIL l0_traffic: got %0d transfers, required 0", rd_log.size() + wr_addr_log.size()); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r; logic d; int c;
      clear_logs(); delay_sel = 2;
      cpu(2'd1, 32'h300, r, d);
      cpu(2'd2, 32'h400, r, d);
      cpu(2'd3, 32'd1, r, d);
      c = 0;
      while (memWrite !== 1'b1 && c < 20) begin @(posedge clock); #1; c++; end
      n_tests++; if (memWrite !== 1'b1) begin n_fail++; $display("FAIL rm_reach_wr: memWrite=%b, required 1", memWrite); end
      #2 nReset = 1'b0;
      #1;
      n_tests++; if (memWrite !== 1'b0 || memAddr !== 32'd0) begin n_fail++; $display("FAIL rm_async: wr=%b addr=%h, required 0 00000000", memWrite, memAddr); end
      @(negedge clock); @(negedge clock);
      nReset = 1'b1; delay_sel = 0;
      repeat (4) begin @(posedge clock); #1; end
      n_tests++; if (memWrite !== 1'b0 || memRead !== 1'b0) begin n_fail++; $display("FAIL rm_idle_bus: rd=%b wr=%b, required 0 0", memRead, memWrite); end
      n_tests++; if (wr_addr_log.size() !== 0) begin n_fail++; $display("FAIL rm_no_write: got %0d writes, required 0", wr_addr_log.size()); end
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL rm_status: got %h, required 00000000", r); end
   endtask

   task automatic test_wrong_id();
      logic [31:0] r; logic d; int c;
      clear_logs(); delay_sel = 0;
      cpu(2'd1, 32'h600, r, d);
      start = 1'b1; isId = 8'h05; valueA = 32'd1; valueB = 32'h500;
      #1;
      n_tests++; if (done !== 1'b0 || result !== 32'd0) begin n_fail++; $display("FAIL wid_resp: done=%b result=%h, required 0 00000000", done, result); end
      @(posedge clock); #1;
      start = 1'b0; isId = 8'h00; valueA = 32'd0; valueB = 32'd0;
      cpu(2'd2, 32'h700, r, d);
      cpu(2'd3, 32'd1, r, d);
      wait_irq(50, c);
      n_tests++; if (rd_log.size() !== 2) begin n_fail++; $display("FAIL wid_rd_count: got %0d, required 2", rd_log.size()); end
      else begin
         n_tests++; if (rd_log[0] !== 32'h600) begin n_fail++; $display("FAIL wid_src_kept: got %h, required 00000600", rd_log[0]); end
      end
      cpu(2'd0, 32'd0, r, d);
      n_tests++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL wid_status: got %h, required 40000000", r); end
   endtask

   initial begin
      nReset = 1'b0; start = 1'b0; valueA = 32'd0; valueB = 32'd0; isId = 8'd0;
      memAck = 1'b0; memReadData = 32'd0;
      delay_sel = 0; wait_cnt = 0; xfer_idx = 0; prev_pend = 1'b0;
      prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = 32'd0; prev_data = 32'd0;
      fork
         forever begin
            @(negedge clock);
            if (!nReset) begin
               memAck = 1'b0; prev_pend = 1'b0; wait_cnt = 0;
            end else begin
               if (prev_pend) begin
                  n_tests++;
                  if (memRead !== prev_rd || memWrite !== prev_wr || memAddr !== prev_addr || memWriteData !== prev_data) begin
                     n_fail++;
                     $display("FAIL req_stable: rd=%b wr=%b addr=%h data=%h, required rd=%b wr=%b addr=%h data=%h",
                              memRead, memWrite, memAddr, memWriteData, prev_rd, prev_wr, prev_addr, prev_data);
                  end
               end
               if (memRead || memWrite) begin
                  cur_delay = (delay_sel == 0) ? 0 : (delay_sel == 1) ? dtab[xfer_idx % 8] : (memWrite ? 1000 : 0);
                  if (wait_cnt >= cur_delay) begin
                     memAck = 1'b1;
                     if (memRead) begin
                        memReadData = mem.exists(memAddr) ? mem[memAddr] : 32'd0;
                        rd_log.push_back(memAddr);
                     end else begin
                        wr_addr_log.push_back(memAddr);
                        wr_data_log.push_back(memWriteData);
                     end
                     wait_cnt = 0; xfer_idx++; prev_pend = 1'b0;
                  end else begin
                     memAck = 1'b0; wait_cnt++; prev_pend = 1'b1;
                     prev_rd = memRead; prev_wr = memWrite; prev_addr = memAddr; prev_data = memWriteData;
                  end
               end else begin
                  memAck = 1'b0; prev_pend = 1'b0; wait_cnt = 0;
               end
            end
         end
      join_none
      repeat (3) @(negedge clock);
      nReset = 1'b1;
      @(posedge clock); #1;
      test_reset();
      test_single();
      test_multi();
      test_back_to_back();
      test_launch0();
      test_reset_mid();
      test_wrong_id();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rgb565_gray_dma_ctrl.md
Name: rgb565_gray_dma_ctrl

Overview:
- Custom-instruction-programmed bus-master controller that sequences RGB565-to-grayscale conversion over a memory buffer.
- CPU writes source address, destination address and group count, then launches.
- Per group: reads two 32-bit words (4 RGB565 pixels), computes 4 grayscale bytes with the team's 54/183/19 weighting, writes one packed 32-bit word.
- Sits between the CPU custom-instruction port and a single-beat memory bus.

Parameters:
- customInstructionID, 8'd0, ID matched against isId.
- COUNT_WIDTH, 16, width of the group counter; one group is 4 pixels.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- start  in  1  custom-instruction strobe.
- valueA  in  32  operation select in [1:0]; bits [31:2] ignored.
- valueB  in  32  operand.
- isId  in  8  instruction ID.
- done  out  1  instruction complete.
- result  out  32  instruction result.
- memAddr  out  32  word address, byte-granular, bits [1:0] always 0.
- memRead  out  1  read request, held until memAck.
- memWrite  out  1  write request, held until memAck.
- memWriteData  out  32  write data.
- memReadData  in  32  read data, valid when memAck=1 during a read.
- memAck  in  1  one-cycle transfer acknowledge.
- irq  out  1  level interrupt, set on job completion.

Behaviour:
- isMe = start && (isId == customInstructionID).
- done = isMe, combinational, same cycle. result = 0 when !isMe.
- Ops on valueA[1:0]:
  - 0 STATUS: result = {busy, irq, {(30-COUNT_WIDTH){0}}, remaining}. Clears irq at the clock edge.
  - 1 SRC: srcAddr <= {valueB[31:2], 2'b00}. result = 0.
  - 2 DST: dstAddr <= {valueB[31:2], 2'b00}. result = 0.
  - 3 LAUNCH: remaining <= valueB[COUNT_WIDTH-1:0] and job starts. result = 0.
- While busy, SRC, DST and LAUNCH are ignored (registers unchanged) and return result = 32'h1. STATUS is always accepted.
- LAUNCH with count 0: no bus traffic, busy stays 0, irq set next cycle.
- FSM states: IDLE, RD0, RD1, WR.
  - IDLE -> RD0 on accepted nonzero LAUNCH.
  - RD0: memRead=1, memAddr=srcAddr. On memAck: word0 <= memReadData, srcAddr += 4, go to RD1.
  - RD1: same as RD0, capturing word1, go to WR.
  - WR: memWrite=1, memAddr=dstAddr, memWriteData=packed. On memAck: dstAddr += 4, remaining -= 1. If the new remaining is 0, go to IDLE and set irq; else go to RD0.
- busy = (state != IDLE).
- Request signals are registered-stable: address, data and strobe do not change until memAck. memAck outside RD0/RD1/WR is ignored.
- Addresses wrap modulo 2^32 with no error.
- Gray math, per pixel p[15:0]:
  - R8 = {p[15:11], 3'b0}, G8 = {p[10:5], 2'b0}, B8 = {p[4:0], 3'b0}.
  - gray = (R8*54 + G8*183 + B8*19) >> 8, using a 16-bit intermediate; take the low 8 bits.
- Packing: packed = {gray(word1[31:16]), gray(word1[15:0]), gray(word0[31:16]), gray(word0[15:0])}.
- Gray logic may be combinational from word0/word1 or pipelined, but WR must present valid data from its first cycle.
- Throughput: 3 bus transfers per group. With zero-wait memAck (ack in the first request cycle), one group completes every 3 cycles.
- Simultaneous STATUS read and job completion in the same cycle: irq ends 1; set has priority over clear.
- Reset, including mid-job: state=IDLE; srcAddr, dstAddr, remaining, word0, word1 = 0; memRead, memWrite, irq = 0; memAddr, memWriteData = 0. No partial-write completion.

Test Plan:
- SRC=0x100, DST=0x203 (stored as 0x200), LAUNCH 1. Memory[0x100]=0x07E0F800, [0x104]=0xFFFF001F -> exactly one write: addr 0x200, data 0xFA12B434. irq=1, STATUS=0x40000000.
- LAUNCH 3 with memAck delayed 0-4 random cycles -> reads 0x100..0x114 in order, writes 0x200/0x204/0x208. Strobe and address stable until ack. remaining decrements 3→2→1→0.
- During a busy job, DST=0x999 -> result 0x1, destination unchanged. STATUS mid-job -> bit31=1 and correct remaining.
- LAUNCH 0 -> no memRead/memWrite, irq=1 next cycle. STATUS returns 0x40000000, then next STATUS returns 0x00000000.
- Drop nReset during WR -> memWrite falls immediately (asynchronously). After release: IDLE, STATUS=0, no write issued.
- Wrong isId with start=1 -> done=0, result=0, no register change.
